pe_inject_scheduler: RTL and testbench

Credit-based injection scheduler sitting between a node's processor element and the router's local (port 5) input. It arbitrates `NUM_SRC` flit sources round-robin at packet granularity and holds each grant from head to tail. It tracks the router's local-input buffer occupancy with a credit counter, so `inject_valid` is never asserted without a free slot. It presents one registered flit stream to the router's `in5`/`vi5` and consumes the router's `co5` credit pulse.

---
 rtl/noc_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/pe_inject_scheduler.sv | 139 +++++++++++++
 tb/tb_pe_inject_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Definitions shared by the router, processor element and injection scheduler:
// flit width, flit-type encodings and the type-field helper.
package noc_pkg;

  localparam int FLIT_W = 20;

  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } inj_state_e;

  function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
    return flit[FLIT_W-1 -: 2];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above the pointer,
// wrapping modulo N. Returns a one-hot grant and its index.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_pos   = '0;
    // Walk from the farthest offset back toward the pointer so the nearest request wins.
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_pos]) begin
        o_grant        = '0;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/pe_inject_scheduler.sv
// Credit-based injection scheduler: packet-granular round-robin over the PE's
// flit sources, feeding one registered flit stream into the router local port.
module pe_inject_scheduler #(
  parameter  int FLIT_W  = noc_pkg::FLIT_W,
  parameter  int NUM_SRC = 4,
  parameter  int CREDITS = 4,
  localparam int CW      = $clog2(CREDITS + 1),
  localparam int OW      = $clog2(NUM_SRC)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_SRC*FLIT_W-1:0] i_src_flit,
  input  logic [NUM_SRC-1:0]        i_src_valid,
  output logic [NUM_SRC-1:0]        o_src_ready,
  output logic [FLIT_W-1:0]         o_inject,
  output logic                      o_inject_valid,
  input  logic                      i_ci,
  output logic [CW-1:0]             o_credit_cnt,
  output logic                      o_busy,
  output logic [OW-1:0]             o_owner,
  output logic                      o_err
);
  import noc_pkg::*;

  // state     | meaning
  // ST_IDLE   | no packet locked; arbitrate among head/single flits
  // ST_LOCKED | owner's packet in flight; only owner served until its tail

  inj_state_e        r_state;
  logic [FLIT_W-1:0] r_inject;
  logic              r_inject_valid;
  logic [CW-1:0]     r_credit_cnt;
  logic [OW-1:0]     r_owner;
  logic [OW-1:0]     r_rr_ptr;
  logic              r_err;

  logic [FLIT_W-1:0]  w_flit [NUM_SRC];
  logic [1:0]         w_type [NUM_SRC];
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_bad_idle;
  logic [NUM_SRC-1:0] w_grant;
  logic [NUM_SRC-1:0] w_owner_oh;
  logic [NUM_SRC-1:0] w_ready;
  logic [OW-1:0]      w_win;
  logic [OW-1:0]      w_sel;
  logic [1:0]         w_sel_type;
  logic               w_has_credit;
  logic               w_xfer;
  logic               w_owner_bad;

  function automatic logic [OW-1:0] ptr_inc(input logic [OW-1:0] p);
    return (p == OW'(NUM_SRC - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_flit[i]     = i_src_flit[i*FLIT_W +: FLIT_W];
      w_type[i]     = flit_type(w_flit[i]);
      w_elig[i]     = i_src_valid[i] && (w_type[i] == FT_HEAD || w_type[i] == FT_SINGLE);
      w_bad_idle[i] = i_src_valid[i] && (w_type[i] == FT_BODY || w_type[i] == FT_TAIL);
    end
  end

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win)
  );

  assign w_has_credit = (r_credit_cnt != '0);
  assign w_owner_oh   = NUM_SRC'(1) << r_owner;

  // Ready is gated by reset so nothing is accepted while the scheduler is held.
  always_comb begin
    w_ready = '0;
    if (i_rst_n && w_has_credit) begin
      if (r_state == ST_IDLE) w_ready = w_grant;
      else                    w_ready = w_owner_oh & i_src_valid;
    end
  end

  assign w_xfer      = |w_ready;
  assign w_sel       = (r_state == ST_IDLE) ? w_win : r_owner;
  assign w_sel_type  = w_type[w_sel];
  assign w_owner_bad = i_src_valid[r_owner] &&
                       (w_type[r_owner] == FT_HEAD || w_type[r_owner] == FT_SINGLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_inject       <= '0;
      r_inject_valid <= 1'b0;
      r_credit_cnt   <= CW'(CREDITS);
      r_owner        <= '0;
      r_rr_ptr       <= '0;
      r_err          <= 1'b0;
    end else begin
      r_inject_valid <= w_xfer;
      if (w_xfer) begin
        r_inject <= w_flit[w_sel];
        r_owner  <= w_sel;
      end

      if (w_xfer && !i_ci) begin
        r_credit_cnt <= r_credit_cnt - 1'b1;
      end else if (!w_xfer && i_ci) begin
        if (r_credit_cnt == CW'(CREDITS)) r_err <= 1'b1;
        else                              r_credit_cnt <= r_credit_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (|w_bad_idle) r_err <= 1'b1;
          if (w_xfer && w_sel_type == FT_HEAD)   r_state  <= ST_LOCKED;
          if (w_xfer && w_sel_type == FT_SINGLE) r_rr_ptr <= ptr_inc(w_sel);
        end
        ST_LOCKED: begin
          // A stray head/single from the owner is flagged but still forwarded.
          if (w_owner_bad) r_err <= 1'b1;
          if (w_xfer && w_sel_type == FT_TAIL) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= ptr_inc(r_owner);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_src_ready    = w_ready;
  assign o_inject       = r_inject;
  assign o_inject_valid = r_inject_valid;
  assign o_credit_cnt   = r_credit_cnt;
  assign o_busy         = (r_state == ST_LOCKED);
  assign o_owner        = r_owner;
  assign o_err          = r_err;

endmodule

// File: tb/tb_pe_inject_scheduler.sv
// Scoreboard bench for pe_inject_scheduler: per-source flit queues drive the
// DUT, expected inject order is queued per scenario and checked at each inject.
module tb_pe_inject_scheduler;

  localparam int FW = 20;
  localparam int NS = 4;
  localparam int CR = 4;

  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS*FW-1:0] src_flit = '0;
  logic [NS-1:0] src_valid = '0;
  logic [NS-1:0] src_ready;
  logic [FW-1:0] inject;
  logic          inject_valid;
  logic          ci = 1'b0;
  logic [2:0]    credit_cnt;
  logic          busy;
  logic [1:0]    owner;
  logic          err;

  pe_inject_scheduler #(.FLIT_W(FW), .NUM_SRC(NS), .CREDITS(CR)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_src_flit     (src_flit),
    .i_src_valid    (src_valid),
    .o_src_ready    (src_ready),
    .o_inject       (inject),
    .o_inject_valid (inject_valid),
    .i_ci           (ci),
    .o_credit_cnt   (credit_cnt),
    .o_busy         (busy),
    .o_owner        (owner),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int inj_count = 0;

  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] src_q [NS][$];
  logic [FW-1:0] exp_flit;
  logic [FW-1:0] pop_tmp;

  bit            drv_en = 1'b0;
  bit            ci_auto = 1'b0;
  bit            ci_pend = 1'b0;
  logic          man_ci = 1'b0;
  logic [NS-1:0] man_valid = '0;
  logic [NS*FW-1:0] man_flit = '0;
  logic [NS-1:0] acc = '0;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [17:0] p);
    return {t, p};
  endfunction

  // Source / credit driver: applies inputs 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NS; i++)
      if (acc[i] && src_q[i].size() > 0) pop_tmp = src_q[i].pop_front();
    if (drv_en) begin
      for (int i = 0; i < NS; i++) begin
        src_valid[i] = (src_q[i].size() > 0);
        src_flit[i*FW +: FW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      end
    end else begin
      src_valid = man_valid;
      src_flit  = man_flit;
    end
    ci = ci_auto ? ci_pend : man_ci;
  end

  // Scoreboard monitor: every inject pops the next expected flit.
  always @(negedge clk) begin
    acc = src_ready;
    checks++;
    if ($countones(src_ready) > 1) begin
      errors++;
      $display("FAIL ready_onehot: src_ready=%b has more than one bit set", src_ready);
    end
    if (inject_valid === 1'b1) begin
      inj_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inject: got %h, no flit expected", inject);
      end else begin
        exp_flit = exp_q.pop_front();
        if (inject !== exp_flit) begin
          errors++;
          $display("FAIL inject_data: got %h want %h", inject, exp_flit);
        end
      end
    end
    ci_pend = ci_auto && (inject_valid === 1'b1);
  end

  task automatic nsample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv_en    = 1'b0;
    ci_auto   = 1'b0;
    man_ci    = 1'b0;
    man_valid = '0;
    rst_n     = 1'b0;
    for (int i = 0; i < NS; i++) src_q[i].delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    nsample();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      nsample();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d flits still expected after %0d cycles", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic pulse_ci();
    man_ci = 1'b1;
    @(posedge clk);
    #2;
    man_ci = 1'b0;
    @(posedge clk);
    nsample();
  endtask

  task automatic test_reset();
    man_valid = '1;
    for (int i = 0; i < NS; i++) man_flit[i*FW +: FW] = mk(T_SINGLE, 18'(8'h50 + i));
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    nsample();
    checks++; if (inject_valid !== 1'b0) begin errors++; $display("FAIL reset_inject_valid: got %b want 0", inject_valid); end
    checks++; if (inject !== '0) begin errors++; $display("FAIL reset_inject: got %h want 0", inject); end
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL reset_src_ready: got %b want 0000", src_ready); end
    checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL reset_credit: got %0d want 4", credit_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    man_valid = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    nsample();
    nsample();
    checks++; if (inj_count !== 0) begin errors++; $display("FAIL reset_no_inject: got %0d injects want 0", inj_count); end
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    ci_auto = 1'b1;
    drv_en  = 1'b1;
    base = inj_count;
    for (int i = 0; i < NS; i++) begin
      exp_q.push_back(mk(T_SINGLE, 18'((i + 1) * 8'h11)));
      src_q[i].push_back(mk(T_SINGLE, 18'((i + 1) * 8'h11)));
    end
    wait_drain("rr_first");
    checks++; if (inj_count !== base + 4) begin errors++; $display("FAIL rr_count: got %0d want %0d", inj_count, base + 4); end
    // Pointer has wrapped to 0: source 0 must win over source 3.
    exp_q.push_back(mk(T_SINGLE, 18'h66));
    exp_q.push_back(mk(T_SINGLE, 18'h55));
    src_q[3].push_back(mk(T_SINGLE, 18'h55));
    src_q[0].push_back(mk(T_SINGLE, 18'h66));
    wait_drain("rr_wrap");
    repeat (4) nsample();
    checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL rr_credit_return: got %0d want 4", credit_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rr_err: got %b want 0", err); end
  endtask

  task automatic test_packet_lock();
    do_reset();
    ci_auto = 1'b1;
    drv_en  = 1'b1;
    exp_q.push_back(mk(T_HEAD, 18'hA1));
    exp_q.push_back(mk(T_BODY, 18'hA2));
    exp_q.push_back(mk(T_TAIL, 18'hA3));
    exp_q.push_back(mk(T_SINGLE, 18'hB1));
    src_q[2].push_back(mk(T_HEAD, 18'hA1));
    src_q[2].push_back(mk(T_BODY, 18'hA2));
    src_q[2].push_back(mk(T_TAIL, 18'hA3));
    @(posedge clk);
    #2;
    src_q[0].push_back(mk(T_SINGLE, 18'hB1));
    @(posedge clk);
    nsample();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy_head: got %b want 1", busy); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL lock_owner: got %0d want 2", owner); end
    checks++; if (src_ready !== 4'b0100) begin errors++; $display("FAIL lock_ready: got %b want 0100", src_ready); end
    nsample();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy_body: got %b want 1", busy); end
    nsample();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_busy_tail: got %b want 0", busy); end
    nsample();
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL lock_next_owner: got %0d want 0", owner); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_single_busy: got %b want 0", busy); end
    wait_drain("lock");
  endtask

  task automatic test_credit_stall();
    int base;
    do_reset();
    drv_en = 1'b1;
    base = inj_count;
    for (int i = 0; i < 6; i++) src_q[1].push_back(mk(T_SINGLE, 18'(12'h101 + i)));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(T_SINGLE, 18'(12'h101 + i)));
    repeat (12) nsample();
    checks++; if (inj_count !== base + 4) begin errors++; $display("FAIL stall_count: got %0d want %0d", inj_count, base + 4); end
    checks++; if (credit_cnt !== 3'd0) begin errors++; $display("FAIL stall_credit: got %0d want 0", credit_cnt); end
    checks++; if (src_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready: got %b want 0000", src_ready); end
    exp_q.push_back(mk(T_SINGLE, 18'h105));
    man_ci = 1'b1;
    @(posedge clk);
    #2;
    man_ci = 1'b0;
    nsample();
    checks++; if (src_ready !== 4'b0000) begin errors++; $display("FAIL stall_ci_comb: got %b want 0000 while ci high", src_ready); end
    nsample();
    checks++; if (credit_cnt !== 3'd1) begin errors++; $display("FAIL stall_credit_back: got %0d want 1", credit_cnt); end
    checks++; if (src_ready !== 4'b0010) begin errors++; $display("FAIL stall_ready_back: got %b want 0010", src_ready); end
    nsample();
    checks++; if (inj_count !== base + 5) begin errors++; $display("FAIL stall_one_more: got %0d want %0d", inj_count, base + 5); end
    checks++; if (credit_cnt !== 3'd0) begin errors++; $display("FAIL stall_credit_spent: got %0d want 0", credit_cnt); end
    repeat (5) nsample();
    checks++; if (inj_count !== base + 5) begin errors++; $display("FAIL stall_hold: got %0d want %0d", inj_count, base + 5); end
  endtask

  task automatic test_simultaneous_overflow();
    do_reset();
    drv_en = 1'b1;
    exp_q.push_back(mk(T_SINGLE, 18'h201));
    src_q[1].push_back(mk(T_SINGLE, 18'h201));
    repeat (2) @(posedge clk);
    nsample();
    checks++; if (credit_cnt !== 3'd3) begin errors++; $display("FAIL sim_first_credit: got %0d want 3", credit_cnt); end
    exp_q.push_back(mk(T_SINGLE, 18'h202));
    src_q[1].push_back(mk(T_SINGLE, 18'h202));
    pulse_ci();
    checks++; if (credit_cnt !== 3'd3) begin errors++; $display("FAIL sim_xfer_and_ci: got %0d want 3", credit_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sim_flit_sent: %0d flits pending want 0", exp_q.size()); end
    pulse_ci();
    checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL sim_ci_only: got %0d want 4", credit_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sim_err_early: got %b want 0", err); end
    pulse_ci();
    checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL ovf_credit: got %0d want 4", credit_cnt); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", err); end
  endtask

  task automatic test_reset_mid_packet();
    int base;
    do_reset();
    drv_en = 1'b1;
    exp_q.push_back(mk(T_HEAD, 18'hC1));
    src_q[3].push_back(mk(T_HEAD, 18'hC1));
    src_q[3].push_back(mk(T_BODY, 18'hC2));
    repeat (2) @(posedge clk);
    nsample();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL mid_owner: got %0d want 3", owner); end
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b want 0", busy); end
    checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL mid_credit: got %0d want 4", credit_cnt); end
    base = inj_count;
    man_flit[1*FW +: FW] = mk(T_BODY, 18'h3C3);
    man_valid = 4'b0010;
    @(posedge clk);
    nsample();
    checks++; if (src_ready !== 4'b0000) begin errors++; $display("FAIL idle_body_ready: got %b want 0000", src_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL idle_body_err_early: got %b want 0", err); end
    nsample();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL idle_body_err: got %b want 1", err); end
    man_valid = '0;
    repeat (3) nsample();
    checks++; if (inj_count !== base) begin errors++; $display("FAIL idle_body_inject: got %0d injects want %0d", inj_count, base); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_body_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_credit_stall();
    test_simultaneous_overflow();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
